// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields (class, registers, funct3, funct7 bit,
// immediate) into RV32I words and queues them in a DEPTH-entry FIFO. Each popped
// word is paired with its instruction-memory address. The address starts at
// BASE_ADDR and advances by 4 per pop.
// Optional feature: define IMM_RANGE_CHK_EN to reject bundles whose immediate
// cannot be represented by the selected instruction format.
module instr_encoder #(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b,
    input  logic [20:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Instruction classes accepted on in_class; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_BR  = 3'd3,
        CLS_IMM = 3'd4,
        CLS_JAL = 3'd5
    } instr_class_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [2:0] F3_WORD = 3'b010;

    logic [31:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic [7:0]        r_err_cnt;

    logic [31:0]       w_word;
    logic [6:0]        w_f7;
    logic              w_class_ok;
    logic              w_imm_ok;
    logic              w_full;
    logic              w_empty;
    logic              w_hs;
    logic              w_push;
    logic              w_pop;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_hs      = in_valid && in_ready;
    assign w_push    = w_hs && w_class_ok && w_imm_ok;
    assign w_pop     = out_valid && out_ready;
    assign w_f7      = in_f7b ? 7'b0100000 : 7'b0000000;

    // Head word is shown only while the FIFO holds data; zero otherwise.
    assign out_data  = w_empty ? 32'h0 : r_mem[r_rd_ptr];
    assign out_addr  = r_addr;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

    // Field packing per instruction class; illegal classes flag w_class_ok low.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_word     = 32'h0;
        w_class_ok = 1'b1;
        case (in_class)
            CLS_R:   w_word = {w_f7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            CLS_LW:  w_word = {in_imm[11:0], in_rs1, F3_WORD, in_rd, OP_LW};
            CLS_SW:  w_word = {in_imm[11:5], in_rs2, in_rs1, F3_WORD, in_imm[4:0], OP_SW};
            CLS_BR:  w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], OP_BR};
            CLS_IMM: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
            CLS_JAL: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, OP_JAL};
            default: w_class_ok = 1'b0;
        endcase
    end

`ifdef IMM_RANGE_CHK_EN
    // Immediate must be representable: sign bits above the field agree, offsets even.
    always_comb begin
        w_imm_ok = 1'b1;
        case (in_class)
            CLS_LW, CLS_SW, CLS_IMM:
                w_imm_ok = (&in_imm[20:11]) || !(|in_imm[20:11]);
            CLS_BR:
                w_imm_ok = ((&in_imm[20:12]) || !(|in_imm[20:12])) && !in_imm[0];
            CLS_JAL:
                w_imm_ok = !in_imm[0];
            default:
                w_imm_ok = 1'b1;
        endcase
    end
`else
    // Without range checking, excess immediate bits are simply truncated.
    assign w_imm_ok = 1'b1;
`endif

    // FIFO storage write; contents are only observed through the count, so no reset.
    // NOTE: storage arrays are left unreset so they map onto plain RAM/flops without reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // FIFO pointers, occupancy and output address tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= BASE_ADDR;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_addr   <= r_addr + ADDR_W'(4);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Rejected-bundle pulse and saturating rejection counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_err <= w_hs && !(w_class_ok && w_imm_ok);
            if (w_hs && !(w_class_ok && w_imm_ok) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed encodings, backpressure, illegal
// bundles, randomized traffic against a queue-based reference model, mid-stream
// reset and error-counter saturation.
module tb_instr_encoder;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int          OBS_W  = 75;

    typedef struct packed {
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b;
        logic [20:0] imm;
    } fields_t;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_f7b;
    logic [20:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [31:0] m_addr;
    logic        m_err;
    int          m_err_cnt;

    instr_encoder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_f7b    (in_f7b),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic fields_t mk(int cls, int rd, int rs1, int rs2, int f3, int f7b, int imm);
        fields_t f;
        f.cls = 3'(cls);
        f.rd  = 5'(rd);
        f.rs1 = 5'(rs1);
        f.rs2 = 5'(rs2);
        f.f3  = 3'(f3);
        f.f7b = 1'(f7b);
        f.imm = 21'(imm);
        return f;
    endfunction

    // Instruction word computed from the format tables with shifts and masks.
    function automatic logic [31:0] ref_encode(fields_t f);
        logic [31:0] u;
        logic [31:0] rd, rs1, rs2, f3;
        u   = {11'b0, f.imm};
        rd  = 32'(f.rd)  << 7;
        rs1 = 32'(f.rs1) << 15;
        rs2 = 32'(f.rs2) << 20;
        f3  = 32'(f.f3)  << 12;
        case (f.cls)
            3'd0: return ((f.f7b ? 32'd32 : 32'd0) << 25) | rs2 | rs1 | f3 | rd | 32'd51;
            3'd1: return ((u & 32'hFFF) << 20) | rs1 | (32'd2 << 12) | rd | 32'd3;
            3'd2: return (((u >> 5) & 32'h7F) << 25) | rs2 | rs1 | (32'd2 << 12)
                         | ((u & 32'h1F) << 7) | 32'd35;
            3'd3: return (((u >> 12) & 32'd1) << 31) | (((u >> 5) & 32'h3F) << 25) | rs2 | rs1
                         | f3 | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'd1) << 7) | 32'd99;
            3'd4: return ((u & 32'hFFF) << 20) | rs1 | f3 | rd | 32'd19;
            3'd5: return (((u >> 20) & 32'd1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                         | (((u >> 11) & 32'd1) << 20) | (((u >> 12) & 32'hFF) << 12) | rd | 32'd111;
            default: return 32'h0;
        endcase
    endfunction

    // Legality from the signed value of the immediate.
    function automatic bit ref_legal(fields_t f);
        int s;
        s = $signed(f.imm);
        if (f.cls > 3'd5) return 1'b0;
`ifdef IMM_RANGE_CHK_EN
        case (f.cls)
            3'd1, 3'd2, 3'd4: return (s >= -2048) && (s <= 2047);
            3'd3:             return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            3'd5:             return (s % 2 == 0);
            default:          return 1'b1;
        endcase
`else
        return (s == s);
`endif
    endfunction

    function automatic fields_t rand_fields(bit allow_illegal);
        fields_t f;
        f.cls = allow_illegal ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
        f.rd  = 5'($urandom);
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.f3  = 3'($urandom);
        f.f7b = 1'($urandom);
        if ($urandom_range(0, 1) == 1) f.imm = 21'($urandom);
        else                           f.imm = 21'($signed(12'($urandom)));
        return f;
    endfunction

    function automatic logic [OBS_W-1:0] model_obs();
        logic [31:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 32'h0;
        return {m_q.size() != 0, m_q.size() < DEPTH, m_err, 8'(m_err_cnt), m_addr, head};
    endfunction

    function automatic logic [OBS_W-1:0] dut_obs();
        return {out_valid, in_ready, err, err_cnt, out_addr, out_data};
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_addr    = BASE;
        m_err     = 1'b0;
        m_err_cnt = 0;
    endtask

    // Drive one cycle from a negedge, advance the model, return at the next negedge.
    task automatic drive_cycle(input bit v, input fields_t f, input bit ordy, output bit acc);
        bit hs, pop;
        in_valid  = v;
        in_class  = f.cls;
        in_rd     = f.rd;
        in_rs1    = f.rs1;
        in_rs2    = f.rs2;
        in_funct3 = f.f3;
        in_f7b    = f.f7b;
        in_imm    = f.imm;
        out_ready = ordy;
        hs  = v && (m_q.size() < DEPTH);
        pop = ordy && (m_q.size() != 0);
        acc = hs && ref_legal(f);
        if (pop) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 32'd4;
        end
        if (acc) m_q.push_back(ref_encode(f));
        m_err = hs && !ref_legal(f);
        if (m_err && m_err_cnt < 255) m_err_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 2 * DEPTH && m_q.size() != 0; i++) begin
            drive_cycle(1'b0, '0, 1'b1, acc);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_class  = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_f7b    = 1'b0;
        in_imm    = '0;
        out_ready = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0)  $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1)   $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_data !== 32'h0)  $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_addr !== BASE)   $display("FAIL reset_out_addr: got %h want %h", out_addr, BASE); else n_pass++;
        n_checks++; if (err !== 1'b0)        $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0)    $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else n_pass++;
    endtask

    // Push one word into an empty FIFO, check it at the head, then pop it.
    task automatic test_encode(input string name, input fields_t f, input logic [31:0] want);
        bit acc;
        logic [31:0] want_addr;
        want_addr = m_addr;
        drive_cycle(1'b1, f, 1'b0, acc);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL %s_valid: got %b want 1", name, out_valid); else n_pass++;
        n_checks++; if (out_data !== want)  $display("FAIL %s_data: got %h want %h", name, out_data, want); else n_pass++;
        n_checks++; if (out_addr !== want_addr) $display("FAIL %s_addr: got %h want %h", name, out_addr, want_addr); else n_pass++;
        drive_cycle(1'b0, '0, 1'b1, acc);
    endtask

    task automatic test_directed();
        bit acc;
        test_encode("r_add", mk(0, 3, 1, 2, 0, 0, 0), 32'h002081B3);
        n_checks++; if (out_addr !== BASE + 32'd4) $display("FAIL r_add_pop_addr: got %h want %h", out_addr, BASE + 32'd4); else n_pass++;
        // LW then SW queued together: order and consecutive addresses.
        drive_cycle(1'b1, mk(1, 5, 2, 0, 0, 0, 8), 1'b0, acc);
        drive_cycle(1'b1, mk(2, 0, 2, 5, 0, 0, 12), 1'b0, acc);
        n_checks++; if (out_data !== 32'h00812283) $display("FAIL lw_data: got %h want 00812283", out_data); else n_pass++;
        n_checks++; if (out_addr !== BASE + 32'd4) $display("FAIL lw_addr: got %h want %h", out_addr, BASE + 32'd4); else n_pass++;
        drive_cycle(1'b0, '0, 1'b1, acc);
        n_checks++; if (out_data !== 32'h00512623) $display("FAIL sw_data: got %h want 00512623", out_data); else n_pass++;
        n_checks++; if (out_addr !== BASE + 32'd8) $display("FAIL sw_addr: got %h want %h", out_addr, BASE + 32'd8); else n_pass++;
        drive_cycle(1'b0, '0, 1'b1, acc);
        test_encode("br", mk(3, 0, 1, 2, 0, 0, -8), 32'hFE208CE3);
        test_encode("jal", mk(5, 1, 0, 0, 0, 0, 16), 32'h010000EF);
        test_encode("sub", mk(0, 7, 8, 9, 0, 1, 0), 32'h409403B3);
    endtask

    task automatic test_backpressure();
        fields_t w[5];
        bit acc;
        bit done;
        for (int i = 0; i < 5; i++) w[i] = rand_fields(1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, w[i], 1'b0, acc);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready: got %b want 0", in_ready); else n_pass++;
        drive_cycle(1'b1, w[4], 1'b0, acc);
        n_checks++; if (out_data !== ref_encode(w[0])) $display("FAIL bp_head_stable: got %h want %h", out_data, ref_encode(w[0])); else n_pass++;
        n_checks++; if (dut_obs() !== model_obs()) $display("FAIL bp_held: got %h want %h", dut_obs(), model_obs()); else n_pass++;
        // Release: 5th word stays offered until the FIFO accepts it, then drain.
        done = 1'b0;
        for (int c = 0; c < 20 && m_q.size() != 0; c++) begin
            drive_cycle(!done, w[4], 1'b1, acc);
            if (acc) done = 1'b1;
            n_checks++; if (dut_obs() !== model_obs()) $display("FAIL bp_release_c%0d: got %h want %h", c, dut_obs(), model_obs()); else n_pass++;
            if (m_q.size() == 1 && done) begin
                n_checks++; if (out_data !== ref_encode(w[4])) $display("FAIL bp_last: got %h want %h", out_data, ref_encode(w[4])); else n_pass++;
            end
        end
        n_checks++; if (!done || out_valid !== 1'b0) $display("FAIL bp_drained: accepted=%b out_valid=%b want 1/0", done, out_valid); else n_pass++;
    endtask

    task automatic test_illegal();
        bit acc;
        drive_cycle(1'b1, mk(6, 1, 2, 3, 0, 0, 0), 1'b1, acc);
        n_checks++; if (err !== 1'b1)     $display("FAIL ill6_err: got %b want 1", err); else n_pass++;
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL ill6_err_cnt: got %0d want 1", err_cnt); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL ill6_no_push: got %b want 0", out_valid); else n_pass++;
        drive_cycle(1'b0, '0, 1'b1, acc);
        n_checks++; if (err !== 1'b0) $display("FAIL ill_err_pulse: got %b want 0", err); else n_pass++;
        drive_cycle(1'b1, mk(7, 0, 0, 0, 0, 0, 0), 1'b1, acc);
        n_checks++; if (err_cnt !== 8'd2) $display("FAIL ill7_err_cnt: got %0d want 2", err_cnt); else n_pass++;
        drive_cycle(1'b1, mk(1, 5, 2, 0, 0, 0, 2048), 1'b0, acc);
`ifdef IMM_RANGE_CHK_EN
        n_checks++; if (err !== 1'b1 || out_valid !== 1'b0) $display("FAIL lw_range: err=%b valid=%b want 1/0", err, out_valid); else n_pass++;
`else
        n_checks++; if (err !== 1'b0 || out_data !== 32'h80012283) $display("FAIL lw_trunc: err=%b data=%h want 0/80012283", err, out_data); else n_pass++;
`endif
        drain();
    endtask

    task automatic test_random();
        bit acc;
        for (int c = 0; c < 400; c++) begin
            drive_cycle($urandom_range(0, 3) != 0, rand_fields(1'b1), $urandom_range(0, 2) != 0, acc);
            n_checks++; if (dut_obs() !== model_obs()) $display("FAIL rand_c%0d: got %h want %h", c, dut_obs(), model_obs()); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        fields_t f;
        drain();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, rand_fields(1'b0), 1'b0, acc);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_addr !== BASE)  $display("FAIL rmid_out_addr: got %h want %h", out_addr, BASE); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0)   $display("FAIL rmid_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        m_reset();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        f = mk(4, 10, 11, 0, 3, 0, -1);
        drive_cycle(1'b1, f, 1'b0, acc);
        n_checks++; if (out_addr !== BASE) $display("FAIL rmid_first_addr: got %h want %h", out_addr, BASE); else n_pass++;
        n_checks++; if (out_data !== ref_encode(f)) $display("FAIL rmid_first_data: got %h want %h", out_data, ref_encode(f)); else n_pass++;
        drain();
    endtask

    task automatic test_err_saturate();
        bit acc;
        for (int c = 0; c < 260; c++) drive_cycle(1'b1, mk(7, 0, 0, 0, 0, 0, 0), 1'b1, acc);
        n_checks++; if (err_cnt !== 8'hFF) $display("FAIL err_sat: got %0d want 255", err_cnt); else n_pass++;
        n_checks++; if (dut_obs() !== model_obs()) $display("FAIL err_sat_obs: got %h want %h", dut_obs(), model_obs()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_mid();
        test_err_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
